// File: rtl/fetch_decode_queue.sv
// Show-ahead instruction queue between fetch and decode; flush discards all entries.
// Optional bubble counter enabled by defining FDQ_BUBBLE_CNT_EN.
module fetch_decode_queue #(
  parameter int DEPTH = 2,
  parameter int PTR_W = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] inst_code,
  input  logic [15:0] pc_input,
  input  logic [1:0]  ex_vector_input,
  input  logic        fetch_valid,
  output logic        fetch_ready,
  input  logic        stall_decode,
  input  logic        flush,
`ifdef FDQ_BUBBLE_CNT_EN
  output logic [15:0] bubble_count,
`endif
  output logic [15:0] inst_out,
  output logic [15:0] pc_out,
  output logic [1:0]  ex_vector_out,
  output logic        valid_out
);

  localparam int ENTRY_W = 34;
  localparam logic [PTR_W:0] FULL_CNT = DEPTH[PTR_W:0];

  logic [ENTRY_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]   rd_ptr;
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W:0]     count;
  logic               push;
  logic               pop;
  logic [ENTRY_W-1:0] head;

  assign fetch_ready = (count < FULL_CNT);
  assign valid_out   = (count != '0);
  assign push        = fetch_valid & fetch_ready & ~flush;
  assign pop         = valid_out & ~stall_decode & ~flush;

  // Entry storage: data only, so it carries no reset
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {ex_vector_input, pc_input, inst_code};
    end
  end

  // Pointers and occupancy; DEPTH is a power of two so pointers wrap naturally
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (push && !pop) begin
        count <= count + 1'b1;
      end else if (pop && !push) begin
        count <= count - 1'b1;
      end
    end
  end

  assign head          = valid_out ? mem[rd_ptr] : '0;
  assign inst_out      = head[15:0];
  assign pc_out        = head[31:16];
  assign ex_vector_out = head[33:32];

`ifdef FDQ_BUBBLE_CNT_EN
  // Counts cycles where decode got nothing; survives flush, saturates
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bubble_count <= '0;
    end else if ((!valid_out || stall_decode) && (bubble_count != 16'hFFFF)) begin
      bubble_count <= bubble_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_decode_queue.sv
// Directed self-checking bench for fetch_decode_queue (DEPTH=2).
module tb_fetch_decode_queue;

  logic        clk;
  logic        reset;
  logic [15:0] inst_code;
  logic [15:0] pc_input;
  logic [1:0]  ex_vector_input;
  logic        fetch_valid;
  logic        fetch_ready;
  logic        stall_decode;
  logic        flush;
  logic [15:0] inst_out;
  logic [15:0] pc_out;
  logic [1:0]  ex_vector_out;
  logic        valid_out;
`ifdef FDQ_BUBBLE_CNT_EN
  logic [15:0] bubble_count;
`endif

  int tests = 0;
  int fails = 0;

  fetch_decode_queue #(.DEPTH(2), .PTR_W(1)) dut (
    .clk            (clk),
    .reset          (reset),
    .inst_code      (inst_code),
    .pc_input       (pc_input),
    .ex_vector_input(ex_vector_input),
    .fetch_valid    (fetch_valid),
    .fetch_ready    (fetch_ready),
    .stall_decode   (stall_decode),
    .flush          (flush),
`ifdef FDQ_BUBBLE_CNT_EN
    .bubble_count   (bubble_count),
`endif
    .inst_out       (inst_out),
    .pc_out         (pc_out),
    .ex_vector_out  (ex_vector_out),
    .valid_out      (valid_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [15:0] inst, input logic [15:0] pc,
                       input logic [1:0] ex);
    fetch_valid     = v;
    inst_code       = inst;
    pc_input        = pc;
    ex_vector_input = ex;
  endtask

  initial begin
    // Reset held with random inputs
    reset        = 1'b0;
    stall_decode = 1'($urandom);
    flush        = 1'($urandom);
    drive(1'b1, 16'($urandom), 16'($urandom), 2'($urandom));
    #3;
    chk("rst_valid", 16'(valid_out), 16'h0);
    chk("rst_inst", inst_out, 16'h0000);
    chk("rst_pc", pc_out, 16'h0000);
    chk("rst_ex", 16'(ex_vector_out), 16'h0);
    chk("rst_ready", 16'(fetch_ready), 16'h1);
    step();
    step();
    chk("rst_hold_valid", 16'(valid_out), 16'h0);
    chk("rst_hold_inst", inst_out, 16'h0000);

    // Release reset, idle
    reset        = 1'b1;
    stall_decode = 1'b0;
    flush        = 1'b0;
    drive(1'b0, 16'h0, 16'h0, 2'b00);
    step();
    chk("idle_valid", 16'(valid_out), 16'h0);
    chk("idle_inst", inst_out, 16'h0000);
    chk("idle_ready", 16'(fetch_ready), 16'h1);
    for (int i = 0; i < 4; i++) step();
`ifdef FDQ_BUBBLE_CNT_EN
    chk("bubble_5", bubble_count, 16'd5);
`endif

    // Single push
    drive(1'b1, 16'hA123, 16'h0010, 2'b00);
    step();
    drive(1'b0, 16'h0, 16'h0, 2'b00);
    chk("single_valid", 16'(valid_out), 16'h1);
    chk("single_inst", inst_out, 16'hA123);
    chk("single_pc", pc_out, 16'h0010);
    step();
    chk("single_drain", 16'(valid_out), 16'h0);
    chk("single_drain_inst", inst_out, 16'h0000);

    // Fill to full while decode stalls
    stall_decode = 1'b1;
    drive(1'b1, 16'h0001, 16'h0001, 2'b00);
    step();
    chk("fill1_inst", inst_out, 16'h0001);
    chk("fill1_ready", 16'(fetch_ready), 16'h1);
    drive(1'b1, 16'h0002, 16'h0002, 2'b00);
    step();
    chk("full_ready", 16'(fetch_ready), 16'h0);
    chk("full_head", inst_out, 16'h0001);
    drive(1'b1, 16'h0003, 16'h0003, 2'b00);
    step();
    chk("full_blocked_ready", 16'(fetch_ready), 16'h0);
    chk("full_blocked_head", inst_out, 16'h0001);
    drive(1'b0, 16'h0, 16'h0, 2'b00);
    stall_decode = 1'b0;
    step();
    chk("pop1_inst", inst_out, 16'h0002);
    chk("pop1_ready", 16'(fetch_ready), 16'h1);
    step();
    chk("pop2_valid", 16'(valid_out), 16'h0);
    chk("pop2_ready", 16'(fetch_ready), 16'h1);

    // Streaming: simultaneous push and pop every cycle
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 16'h0100 + 16'(i), 16'(i), 2'b00);
      step();
      chk("stream_valid", 16'(valid_out), 16'h1);
      chk("stream_pc", pc_out, 16'(i));
      chk("stream_inst", inst_out, 16'h0100 + 16'(i));
    end
    drive(1'b0, 16'h0, 16'h0, 2'b00);
    step();
    chk("stream_end", 16'(valid_out), 16'h0);

    // Flush with full queue and concurrent fetch
    stall_decode = 1'b1;
    drive(1'b1, 16'hC001, 16'h0020, 2'b00);
    step();
    drive(1'b1, 16'hC002, 16'h0021, 2'b00);
    step();
    chk("preflush_valid", 16'(valid_out), 16'h1);
    chk("preflush_ready", 16'(fetch_ready), 16'h0);
    flush = 1'b1;
    drive(1'b1, 16'hBEEF, 16'h0030, 2'b00);
    step();
    flush = 1'b0;
    drive(1'b0, 16'h0, 16'h0, 2'b00);
    chk("flush_valid", 16'(valid_out), 16'h0);
    chk("flush_ready", 16'(fetch_ready), 16'h1);
    chk("flush_inst", inst_out, 16'h0000);

    // Flush with one entry, so the concurrent push would be accepted if not dropped
    drive(1'b1, 16'hD001, 16'h0040, 2'b00);
    step();
    chk("d001_head", inst_out, 16'hD001);
    flush = 1'b1;
    drive(1'b1, 16'hBEEF, 16'h0041, 2'b00);
    step();
    flush = 1'b0;
    drive(1'b0, 16'h0, 16'h0, 2'b00);
    chk("flush2_valid", 16'(valid_out), 16'h0);
    stall_decode = 1'b0;
    step();
    chk("flush2_no_beef", 16'(valid_out), 16'h0);
    chk("flush2_inst", inst_out, 16'h0000);

    // Post-flush pointers restart at entry 0
    drive(1'b1, 16'hE001, 16'h0050, 2'b00);
    step();
    drive(1'b0, 16'h0, 16'h0, 2'b00);
    chk("postflush_inst", inst_out, 16'hE001);
    step();

    // Exception passthrough
    drive(1'b1, 16'h5555, 16'h0042, 2'b10);
    step();
    drive(1'b0, 16'h0, 16'h0, 2'b00);
    chk("exc_valid", 16'(valid_out), 16'h1);
    chk("exc_ex", 16'(ex_vector_out), 16'h2);
    chk("exc_pc", pc_out, 16'h0042);
    step();
    chk("exc_drain_ex", 16'(ex_vector_out), 16'h0);

    // Reset asserted mid-stream clears the queue
    stall_decode = 1'b1;
    drive(1'b1, 16'hF001, 16'h0060, 2'b01);
    step();
    drive(1'b1, 16'hF002, 16'h0061, 2'b01);
    step();
    drive(1'b0, 16'h0, 16'h0, 2'b00);
    chk("prerst_valid", 16'(valid_out), 16'h1);
    #2;
    reset = 1'b0;
    #1;
    chk("midrst_valid", 16'(valid_out), 16'h0);
    chk("midrst_ready", 16'(fetch_ready), 16'h1);
    step();
    reset        = 1'b1;
    stall_decode = 1'b0;
    step();
    chk("postrst_valid", 16'(valid_out), 16'h0);
    chk("postrst_inst", inst_out, 16'h0000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
